pix_pack_ctrl: RTL and testbench
================================

PIX_PACK_CTRL -- requirements
Module: pix_pack_ctrl

Interface
REQ-001 SHALL have parameter PARALLEL_NUM, default 4, pixels per beat (fixed 4 for 128-bit packing).
REQ-002 SHALL have parameter H_PIXELS, default 1920, active pixels per line (multiple of PARALLEL_NUM).
REQ-003 SHALL have parameter V_LINES, default 1080, active lines per frame.
REQ-004 SHALL have port i_clk  in  1  sole clock.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_enable  in  1  frame capture enable.
REQ-007 SHALL have port i_valid  in  1  input pixel group valid.
REQ-008 SHALL have port o_ready  out  1  input accept.
REQ-009 SHALL have port i_sof  in  1  first group of frame, qualified by i_valid.
REQ-010 SHALL have ports i_rgb_r, i_rgb_g, i_rgb_b  in  PARALLEL_NUM x 8  per-pixel channels, index 0 = first pixel.
REQ-011 SHALL have port o_tdata  out  128  packed beat.
REQ-012 SHALL have ports o_tvalid  out  1, i_tready  in  1, o_tlast  out  1 (last beat of line), o_tuser  out  1 (first beat of frame).
REQ-013 SHALL have ports o_busy  out  1 (frame in progress) and o_err  out  1 (sticky length error).

Function
REQ-014 SHALL pack pixel n into o_tdata[32n+31:32n] as {pad, R, G, B}, pad = 8'h00 unless REQ-030 applies.
REQ-015 SHALL use FSM states IDLE, WAIT_SOF, ACTIVE, DRAIN.
REQ-016 SHALL go IDLE->WAIT_SOF when i_enable=1; in IDLE o_ready=1 and inputs are discarded.
REQ-017 SHALL, in WAIT_SOF, discard groups with i_sof=0 (o_ready=1) and go to ACTIVE on an accepted group with i_sof=1, which becomes beat 0 of line 0.
REQ-018 SHALL count beats 0..H_PIXELS/PARALLEL_NUM-1 per line and lines 0..V_LINES-1, advancing only on input accept (i_valid & o_ready).
REQ-019 SHALL set o_tlast on the beat with beat count H_PIXELS/PARALLEL_NUM-1 and o_tuser only on beat 0 of line 0.
REQ-020 SHALL go ACTIVE->DRAIN after accepting the last beat of line V_LINES-1; DRAIN->WAIT_SOF (i_enable=1) or IDLE (i_enable=0) once output buffer empty.
REQ-021 SHALL, on i_sof=1 accepted in ACTIVE at other than line 0 beat 0 position, set o_err and restart counters with that group as new frame beat 0 (tuser=1).
REQ-022 SHALL complete the current frame when i_enable drops in ACTIVE; i_enable checked only at frame boundaries.
REQ-023 SHALL buffer output through a 2-entry skid buffer: o_ready = buffer not full (in ACTIVE), o_tvalid = buffer not empty; o_tdata/o_tlast/o_tuser held stable while o_tvalid=1 and i_tready=0.
REQ-024 SHALL give 1-cycle latency input accept to o_tvalid and sustain 1 beat/cycle with i_tready held 1.
REQ-025 SHALL handle simultaneous push and pop on a full buffer without loss or duplication.
REQ-026 SHALL assert o_busy in ACTIVE and DRAIN.

Reset
REQ-027 SHALL on i_rst_n=0 asynchronously force: state IDLE, counters 0, buffer empty, o_tvalid=0, o_tlast=0, o_tuser=0, o_tdata=0, o_err=0, o_busy=0, o_ready=0.
REQ-028 SHALL drop any partial frame on reset mid-frame; after release resync waits for i_sof.
REQ-029 SHALL clear o_err only by reset.

Configuration
REQ-030 SHALL, with macro PIX_PACK_ALPHA_EN defined, add port i_alpha in 8 and place it in every pad byte, sampled at frame start (beat 0 accept) and constant within the frame; without it, no i_alpha port and pad = 8'h00.

Structure
REQ-031 SHALL place state enum, BEAT_W=128, PIX_W=32, and beat/line counter width functions in package pix_pack_pkg.
REQ-032 SHALL implement the 2-entry buffer as sub-module pix_skid_buf (data 130 bits: tdata, tlast, tuser).

Verification
REQ-033 SHALL test: H_PIXELS=8, V_LINES=2, pixel n R=n,G=n+16,B=n+32, i_tready=1 -> 4 beats, beat0 tdata[31:0]=32'h00_00_10_20, tuser on beat0 only, tlast on beats 1 and 3.
REQ-034 SHALL test: i_tready toggling 1/0 each cycle over full frame -> no beat lost/duplicated, data stable while stalled, o_ready low when 2 beats held.
REQ-035 SHALL test: i_sof at line 1 beat 1 -> o_err=1, next beat tuser=1, counters restarted.
REQ-036 SHALL test: i_enable dropped mid-frame -> frame completes, state IDLE after last beat drains, o_busy=0.
REQ-037 SHALL test: i_rst_n low mid-line with o_tvalid=1 -> o_tvalid=0 immediately; groups before next i_sof discarded.
REQ-038 SHALL test with PIX_PACK_ALPHA_EN, i_alpha=8'hFF -> every pad byte 8'hFF.

Source files
------------

// File: rtl/pix_pack_pkg.sv
// pix_pack_pkg: shared types, widths and counter sizing for the pixel packer
package pix_pack_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DRAIN} state_t;
  localparam int BEAT_W = 128;
  localparam int PIX_W = 32;
  function automatic int beat_cnt_w(input int h, input int p);
    return (h / p > 1) ? $clog2(h / p) : 1;
  endfunction
  function automatic int line_cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/pix_pack_if.sv
// pix_pack_if: pixel-group input stream and 128-bit packed output stream
interface pix_pack_if #(parameter int PARALLEL_NUM = 4);
  import pix_pack_pkg::*;
  logic i_valid, o_ready, i_sof;
  logic [PARALLEL_NUM-1:0][7:0] i_rgb_r, i_rgb_g, i_rgb_b;
  logic [BEAT_W-1:0] o_tdata;
  logic o_tvalid, i_tready, o_tlast, o_tuser;
  modport slave(input i_valid, i_sof, i_rgb_r, i_rgb_g, i_rgb_b, i_tready,
                output o_ready, o_tdata, o_tvalid, o_tlast, o_tuser);
  modport master(output i_valid, i_sof, i_rgb_r, i_rgb_g, i_rgb_b, i_tready,
                 input o_ready, o_tdata, o_tvalid, o_tlast, o_tuser);
endinterface

// File: rtl/pix_skid_buf.sv
// pix_skid_buf: 2-entry output buffer; the head register drives the outputs directly
module pix_skid_buf #(parameter int W = 130) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic [W-1:0] q1;
  logic [1:0] n;
  logic pop, psh;
  assign o_valid = n != 2'd0;
  assign o_full = n == 2'd2;
  assign pop = o_valid & i_ready;
  assign psh = i_push & (!o_full | pop);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      n <= '0;
      o_data <= '0;
      q1 <= '0;
    end else begin
      n <= n + 2'(psh) - 2'(pop);
      if (psh && (n == 2'd0 || (n == 2'd1 && pop))) o_data <= i_data;
      else if (pop && n == 2'd2) o_data <= q1;
      if (psh && ((n == 2'd1 && !pop) || (n == 2'd2 && pop))) q1 <= i_data;
    end
endmodule

// File: rtl/pix_pack_ctrl.sv
// pix_pack_ctrl: frame-synchronised RGB packer, PARALLEL_NUM x {pad,R,G,B} per 128-bit beat.
// Define PIX_PACK_ALPHA_EN to add i_alpha, latched at frame start into every pad byte.
module pix_pack_ctrl
  import pix_pack_pkg::*;
#(
  parameter int PARALLEL_NUM = 4,
  parameter int H_PIXELS = 1920,
  parameter int V_LINES = 1080
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
`ifdef PIX_PACK_ALPHA_EN
  input  logic [7:0] i_alpha,
`endif
  pix_pack_if.slave  bus,
  output logic       o_busy,
  output logic       o_err
);
  localparam int HB = H_PIXELS / PARALLEL_NUM;
  localparam int BW = beat_cnt_w(H_PIXELS, PARALLEL_NUM);
  localparam int LW = line_cnt_w(V_LINES);
  localparam logic [BW-1:0] LAST_B = BW'(HB - 1);
  localparam logic [LW-1:0] LAST_L = LW'(V_LINES - 1);
  state_t state;
  logic [BW-1:0] bc, eb;
  logic [LW-1:0] lc, el;
  logic acc, push, full, first, last_b, last_l;
  logic [7:0] pad;
  logic [BEAT_W-1:0] px;
  logic [BEAT_W+1:0] ob;
  assign acc = bus.i_valid & bus.o_ready;
  assign push = acc & ((state == ACTIVE) | ((state == WAIT_SOF) & bus.i_sof));
  // an accepted sof always repositions this group to line 0 beat 0
  assign eb = bus.i_sof ? '0 : bc;
  assign el = bus.i_sof ? '0 : lc;
  assign first = (eb == '0) && (el == '0);
  assign last_b = eb == LAST_B;
  assign last_l = el == LAST_L;
  assign bus.o_ready = i_rst_n & ((state == ACTIVE) ? !full : (state != DRAIN));
  assign o_busy = (state == ACTIVE) || (state == DRAIN);
`ifdef PIX_PACK_ALPHA_EN
  logic [7:0] alpha_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) alpha_q <= '0;
    else if (push && first) alpha_q <= i_alpha;
  assign pad = first ? i_alpha : alpha_q;
`else
  assign pad = 8'h00;
`endif
  always_comb begin
    px = '0;
    for (int k = 0; k < PARALLEL_NUM; k++)
      px[PIX_W*k +: PIX_W] = {pad, bus.i_rgb_r[k], bus.i_rgb_g[k], bus.i_rgb_b[k]};
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      bc <= '0;
      lc <= '0;
      o_err <= 1'b0;
    end else begin
      if (push && state == ACTIVE && bus.i_sof && (bc != '0 || lc != '0)) o_err <= 1'b1;
      if (push) begin
        bc <= last_b ? '0 : eb + 1'b1;
        lc <= last_b ? (last_l ? '0 : el + 1'b1) : el;
      end
      case (state)
        IDLE:             if (i_enable) state <= WAIT_SOF;
        WAIT_SOF, ACTIVE: if (push) state <= (last_b && last_l) ? DRAIN : ACTIVE;
        DRAIN:            if (!bus.o_tvalid) state <= i_enable ? WAIT_SOF : IDLE;
        default:          state <= IDLE;
      endcase
    end
  pix_skid_buf #(.W(BEAT_W + 2)) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  ({px, last_b, first}),
    .o_full  (full),
    .o_valid (bus.o_tvalid),
    .i_ready (bus.i_tready),
    .o_data  (ob)
  );
  assign {bus.o_tdata, bus.o_tlast, bus.o_tuser} = ob;
endmodule

// File: tb/tb_pix_pack_ctrl.sv
// tb_pix_pack_ctrl: frame-level model and scoreboard for the pixel packer, 8x2 frame of 4 beats
module tb_pix_pack_ctrl;
  localparam int P = 4, H = 8, V = 2, NB = (H / P) * V;
`ifdef PIX_PACK_ALPHA_EN
  localparam logic [7:0] PAD = 8'hFF;
`else
  localparam logic [7:0] PAD = 8'h00;
`endif
  typedef struct packed {logic [127:0] d; logic l; logic u;} beat_t;
  logic i_clk = 0, i_rst_n = 0, i_enable = 0;
  logic o_busy, o_err;
  int checks = 0, failures = 0;
  beat_t q[$], got[$];
  bit armed = 0, in_frame = 0, m_err = 0, tog = 0;
  int pos = 0, full_seen = 0;
  pix_pack_if #(.PARALLEL_NUM(P)) bus();
`ifdef PIX_PACK_ALPHA_EN
  logic [7:0] i_alpha = 8'hFF;
`endif
  pix_pack_ctrl #(.PARALLEL_NUM(P), .H_PIXELS(H), .V_LINES(V)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_enable),
`ifdef PIX_PACK_ALPHA_EN
    .i_alpha  (i_alpha),
`endif
    .bus      (bus),
    .o_busy   (o_busy),
    .o_err    (o_err)
  );
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // model: a frame is NB beats counted from an accepted sof; beat pos 0 carries tuser,
  // every (H/P)-th beat carries tlast, a sof mid-frame is an error and restarts at pos 0
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      q.delete();
      armed = 0; in_frame = 0; pos = 0; m_err = 0;
      chk("rst_tvalid", bus.o_tvalid, 0);
      chk("rst_ready", bus.o_ready, 0);
    end else begin
      chk("tvalid", bus.o_tvalid, q.size() != 0);
      if (q.size() != 0) begin
        chk("tdata", bus.o_tdata, q[0].d);
        chk("tlast", bus.o_tlast, q[0].l);
        chk("tuser", bus.o_tuser, q[0].u);
      end
      chk("err", o_err, m_err);
      if (in_frame) begin
        chk("ready", bus.o_ready, q.size() < 2);
        if (q.size() == 2 && !bus.o_ready) full_seen++;
      end
      if (bus.o_tvalid && bus.i_tready) begin
        got.push_back('{bus.o_tdata, bus.o_tlast, bus.o_tuser});
        if (q.size() != 0) void'(q.pop_front());
      end
      if (bus.i_valid && bus.o_ready) begin
        if (bus.i_sof && (armed || in_frame)) begin
          if (in_frame && pos != 0) m_err = 1;
          pos = 0; in_frame = 1;
        end
        if (in_frame) begin
          beat_t b;
          b.d = '0;
          for (int k = 0; k < P; k++)
            b.d[32*k +: 32] = {PAD, bus.i_rgb_r[k], bus.i_rgb_g[k], bus.i_rgb_b[k]};
          b.u = pos == 0;
          b.l = (pos % (H / P)) == (H / P) - 1;
          q.push_back(b);
          pos++;
          if (pos == NB) begin in_frame = 0; armed = 0; pos = 0; end
        end
      end
      if (i_enable && !in_frame) armed = 1;
    end
  end

  always @(posedge i_clk) begin
    #1;
    if (tog) bus.i_tready = ~bus.i_tready;
  end

  task automatic send(input logic sof, input int g);
    int t = 0;
    bus.i_valid = 1; bus.i_sof = sof;
    for (int k = 0; k < P; k++) begin
      bus.i_rgb_r[k] = 8'(4 * g + k);
      bus.i_rgb_g[k] = 8'(4 * g + k + 16);
      bus.i_rgb_b[k] = 8'(4 * g + k + 32);
    end
    @(negedge i_clk);
    while (!bus.o_ready && t < 50) begin @(negedge i_clk); t++; end
    if (t >= 50) begin checks++; failures++; $display("FAIL send_timeout actual=%0d required=<50", t); end
    @(posedge i_clk); #1;
    bus.i_valid = 0; bus.i_sof = 0;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge i_clk);
    while ((q.size() != 0 || bus.o_tvalid) && t < 100) begin @(negedge i_clk); t++; end
    if (t >= 100) begin checks++; failures++; $display("FAIL drain_timeout actual=%0d required=<100", t); end
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] us, ls;
    bus.i_valid = 0; bus.i_sof = 0; bus.i_tready = 1;
    bus.i_rgb_r = '0; bus.i_rgb_g = '0; bus.i_rgb_b = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_tdata", bus.o_tdata, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_err", o_err, 0);
    chk("reset_ready", bus.o_ready, 0);
    i_rst_n = 1;
    // basic frame, a stray non-sof group first
    i_enable = 1;
    repeat (2) @(posedge i_clk);
    #1;
    send(0, 9);
    send(1, 0); send(0, 1); send(0, 2); send(0, 3);
    drain();
    chk("t1_beats", got.size(), 4);
    if (got.size() == 4) begin
      chk("t1_beat0", got[0].d, {PAD, 24'h031323, PAD, 24'h021222, PAD, 24'h011121, PAD, 24'h001020});
      chk("t1_beat0_px0", got[0].d[31:0], {PAD, 24'h001020});
      for (int i = 0; i < 4; i++) begin us[i] = got[i].u; ls[i] = got[i].l; end
      chk("t1_tuser", us, 4'b0001);
      chk("t1_tlast", ls, 4'b1010);
    end
    // backpressure toggling every cycle
    got.delete();
    tog = 1;
    send(1, 8); send(0, 9); send(0, 10); send(0, 11);
    drain();
    tog = 0; bus.i_tready = 1;
    chk("t2_beats", got.size(), 4);
    chk("t2_full_seen", full_seen > 0, 1);
    // sof at line 1 beat 1
    got.delete();
    send(1, 0); send(0, 1); send(0, 2); send(1, 3);
    send(0, 4); send(0, 5); send(0, 6);
    drain();
    chk("t3_err", o_err, 1);
    chk("t3_beats", got.size(), 7);
    if (got.size() == 7) begin
      chk("t3_restart_tuser", got[3].u, 1);
      chk("t3_restart_px0", got[3].d[31:0], {PAD, 24'h0C1C2C});
      chk("t3_end_tlast", got[6].l, 1);
    end
    // enable dropped mid-frame
    got.delete();
    send(1, 0); send(0, 1);
    i_enable = 0;
    send(0, 2); send(0, 3);
    drain();
    chk("t4_beats", got.size(), 4);
    chk("t4_busy", o_busy, 0);
    send(1, 0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("t4_idle_discard", got.size(), 4);
    chk("t4_idle_ready", bus.o_ready, 1);
    // reset mid-line with beats held
    i_enable = 1;
    repeat (2) @(posedge i_clk);
    #1;
    bus.i_tready = 0;
    send(1, 0); send(0, 1);
    @(posedge i_clk);
    #2;
    chk("t5_pre_tvalid", bus.o_tvalid, 1);
    chk("t5_pre_ready", bus.o_ready, 0);
    i_rst_n = 0;
    #1;
    chk("t5_rst_tvalid", bus.o_tvalid, 0);
    chk("t5_rst_tdata", bus.o_tdata, 0);
    chk("t5_rst_tuser", bus.o_tuser, 0);
    chk("t5_rst_err", o_err, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1; bus.i_tready = 1;
    got.delete();
    repeat (2) @(posedge i_clk);
    #1;
    send(0, 1); send(0, 2);
    send(1, 4); send(0, 5); send(0, 6); send(0, 7);
    drain();
    chk("t5_beats", got.size(), 4);
    if (got.size() == 4) chk("t5_first_px0", got[0].d[31:0], {PAD, 24'h102030});
    chk("t5_err", o_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
